// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: bus widths, capture FSM states and byte-strobe masking.
package axis_pkg;

  localparam int AXIS_DW = 32;
  localparam int AXIS_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } cap_state_e;

  // Bytes whose strobe bit is low are stored as zero.
  function automatic logic [AXIS_DW-1:0] axis_strb_mask(
    input logic [AXIS_DW-1:0] data,
    input logic [AXIS_SW-1:0] strb
  );
    logic [AXIS_DW-1:0] res;
    res = '0;
    for (int i = 0; i < AXIS_SW; i++) begin
      res[8*i +: 8] = strb[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_capture_ram.sv
// Simple dual-port word buffer: one write port, one registered read port returning old data on collision.
module axis_capture_ram
  import axis_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [AXIS_DW-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [AXIS_DW-1:0] rd_data
);

  logic [AXIS_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the array sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_capture.sv
// AXI4-Stream packet capture: one packet per ARM into a word buffer, with count/done/overflow status.
module axis_capture
  import axis_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [AXIS_DW-1:0] AXIS_TDATA,
  input  logic [AXIS_SW-1:0] AXIS_TSTRB,
  input  logic               AXIS_TKEEP,
  input  logic               AXIS_TLAST,
  input  logic               AXIS_TVALID,
  output logic               AXIS_TREADY,
  input  logic               ARM,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVERFLOW,
  output logic [AW:0]        WORD_COUNT,
  input  logic [AW-1:0]      RD_ADDR,
  output logic [AXIS_DW-1:0] RD_DATA
);

  cap_state_e state_reg, state_next;
  logic [AW:0] count_reg, count_next;
  logic        overflow_reg, overflow_next;
  logic        beat, room, wr_en;
  logic        unused_keep;

  assign unused_keep = AXIS_TKEEP;

  assign beat  = AXIS_TVALID && (state_reg == ST_RECV);
  // Count saturates at DEPTH, so the top bit alone marks a full buffer.
  assign room  = (count_reg[AW] == 1'b0);
  assign wr_en = beat && room;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (ARM) begin
          state_next    = ST_RECV;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      ST_RECV: begin
        if (beat) begin
          if (room) begin
            count_next = count_reg + 1'b1;
          end else begin
            overflow_next = 1'b1;
          end
          if (AXIS_TLAST) begin
            state_next = ST_DONE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign AXIS_TREADY = (state_reg == ST_RECV);
  assign BUSY        = (state_reg == ST_RECV);
  assign DONE        = (state_reg == ST_DONE);
  assign OVERFLOW    = overflow_reg;
  assign WORD_COUNT  = count_reg;

  axis_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (CLK),
    .srst    (RST),
    .wr_en   (wr_en),
    .wr_addr (count_reg[AW-1:0]),
    .wr_data (axis_strb_mask(AXIS_TDATA, AXIS_TSTRB)),
    .rd_addr (RD_ADDR),
    .rd_data (RD_DATA)
  );

endmodule
